// File: rtl/zbt_arbiter.sv
// -----------------------------------------------------------------------------
// zbt_arbiter
//
// Shares one ZBT SRAM (behind zbt_6111) between a read requester (scan-out)
// and a write requester (capture path), and adds a fill engine that writes
// CLEAR_DATA to addresses 0..CLEAR_LAST. Reads have priority, but a waiting
// write is forced through after STARVE_LIMIT consecutive read grants. Read
// requests are tagged through the two-cycle ZBT pipeline so that only real
// reads produce rd_valid.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   rd_req/rd_addr/rd_ack       read request handshake (ack is combinational)
//   rd_data/rd_valid            returned read word and its one-cycle strobe
//   wr_req/wr_addr/wr_data      write request (held until wr_ack)
//   wr_ack                      combinational write accept
//   clear_start/clear_busy      fill engine start pulse / running flag
//   zbt_cen/zbt_we/zbt_addr/
//   zbt_write_data              control and data toward zbt_6111
//   zbt_read_data               read data from zbt_6111
// -----------------------------------------------------------------------------
module zbt_arbiter #(
    parameter int          STARVE_LIMIT = 4,
    parameter logic [18:0] CLEAR_LAST   = 19'h7FFFF,
    parameter logic [35:0] CLEAR_DATA   = 36'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_req,
    input  logic [18:0] rd_addr,
    output logic        rd_ack,
    output logic [35:0] rd_data,
    output logic        rd_valid,
    input  logic        wr_req,
    input  logic [18:0] wr_addr,
    input  logic [35:0] wr_data,
    output logic        wr_ack,
    input  logic        clear_start,
    output logic        clear_busy,
    output logic        zbt_cen,
    output logic        zbt_we,
    output logic [18:0] zbt_addr,
    output logic [35:0] zbt_write_data,
    input  logic [35:0] zbt_read_data
);

    localparam int          SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic {S_RUN = 1'b0, S_CLEAR = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [18:0]    fill_cnt_q, fill_cnt_d;
    logic [SW-1:0]  starve_q, starve_d;
    logic [2:0]     tag_q, tag_d;
    logic [35:0]    rd_data_q, rd_data_d;
    logic           rd_valid_q, rd_valid_d;
    logic           we_q, we_d;
    logic [18:0]    addr_q, addr_d;
    logic [35:0]    wdata_q, wdata_d;

    logic           rd_grant, wr_grant;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_RUN;
            fill_cnt_q <= '0;
            starve_q   <= '0;
            tag_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            starve_q   <= starve_d;
            tag_q      <= tag_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RUN:   if (clear_start)              state_d = S_CLEAR;
            S_CLEAR: if (fill_cnt_q == CLEAR_LAST) state_d = S_RUN;
            default:                               state_d = S_RUN;
        endcase
    end

    // ---------------- FSM outputs (grants) ----------------
    // A clear_start in RUN claims the cycle, so no request is acked with it.
    always_comb begin
        rd_grant = 1'b0;
        wr_grant = 1'b0;
        if (!reset && state_q == S_RUN && !clear_start) begin
            if (wr_req && (!rd_req || starve_q == STARVE_MAX)) begin
                wr_grant = 1'b1;
            end else if (rd_req) begin
                rd_grant = 1'b1;
            end
        end
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        fill_cnt_d = fill_cnt_q;
        starve_d   = starve_q;
        we_d       = 1'b0;        // idle cycles issue an untagged read
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        if (state_q == S_CLEAR) begin
            we_d       = 1'b1;
            addr_d     = fill_cnt_q;
            wdata_d    = CLEAR_DATA;
            fill_cnt_d = fill_cnt_q + 19'd1;
        end else if (clear_start) begin
            fill_cnt_d = '0;
        end else if (wr_grant) begin
            we_d    = 1'b1;
            addr_d  = wr_addr;
            wdata_d = wr_data;
        end else if (rd_grant) begin
            addr_d  = rd_addr;
        end

        // Starve counter only measures reads granted while a write waits.
        if (!wr_req || wr_grant) begin
            starve_d = '0;
        end else if (rd_grant) begin
            starve_d = starve_q + 1'b1;
        end

        // Tag bit k set means a real read is k+1 cycles past its ack edge;
        // the ZBT returns data while the oldest stage is set.
        tag_d      = {tag_q[1:0], rd_grant};
        rd_valid_d = tag_q[2];
        rd_data_d  = tag_q[2] ? zbt_read_data : rd_data_q;
    end

    // The ZBT clock enable must never drop outside reset: zbt_6111 would
    // freeze its write-data pipeline and misplace in-flight writes.
    assign zbt_cen        = ~reset;
    assign zbt_we         = we_q;
    assign zbt_addr       = addr_q;
    assign zbt_write_data = wdata_q;

    assign rd_ack     = rd_grant;
    assign wr_ack     = wr_grant;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign clear_busy = (state_q == S_CLEAR);

endmodule

// File: tb/tb_zbt_arbiter.sv
// -----------------------------------------------------------------------------
// tb_zbt_arbiter
//
// Self-checking bench for zbt_arbiter with CLEAR_LAST=7. A small behavioural
// ZBT model (two-stage command pipeline, 256-word memory) sits on the zbt_*
// ports. Arbitration is checked from a vector table; reset, data path, fill
// and reset-during-fill are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_zbt_arbiter;

    localparam logic [35:0] INIT_PAT = 36'h5A5A00000;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_req;
    logic [18:0] rd_addr;
    logic        rd_ack;
    logic [35:0] rd_data;
    logic        rd_valid;
    logic        wr_req;
    logic [18:0] wr_addr;
    logic [35:0] wr_data;
    logic        wr_ack;
    logic        clear_start;
    logic        clear_busy;
    logic        zbt_cen;
    logic        zbt_we;
    logic [18:0] zbt_addr;
    logic [35:0] zbt_write_data;
    logic [35:0] zbt_read_data;

    always #5 clk = ~clk;

    zbt_arbiter #(
        .STARVE_LIMIT(4),
        .CLEAR_LAST  (19'd7),
        .CLEAR_DATA  (36'h0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_ack        (rd_ack),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .wr_req        (wr_req),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_ack        (wr_ack),
        .clear_start   (clear_start),
        .clear_busy    (clear_busy),
        .zbt_cen       (zbt_cen),
        .zbt_we        (zbt_we),
        .zbt_addr      (zbt_addr),
        .zbt_write_data(zbt_write_data),
        .zbt_read_data (zbt_read_data)
    );

    // ---------------- ZBT model ----------------
    // Command on the bus in cycle c reaches stage 2 in c+2: read data is
    // driven then, and a write lands in memory at the end of that cycle.
    logic [35:0] mem [0:255];
    logic        s1_we = 1'b0, s2_we = 1'b0;
    logic [18:0] s1_addr = '0, s2_addr = '0;
    logic [35:0] s1_data = '0, s2_data = '0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = INIT_PAT | 36'(i);
    end

    always @(posedge clk) begin
        if (zbt_cen === 1'b1) begin
            if (s2_we === 1'b1) mem[s2_addr[7:0]] <= s2_data;
            s2_we   <= s1_we;
            s2_addr <= s1_addr;
            s2_data <= s1_data;
            s1_we   <= zbt_we;
            s1_addr <= zbt_addr;
            s1_data <= zbt_write_data;
        end
    end

    assign zbt_read_data = mem[s2_addr[7:0]];

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_write(input logic [18:0] a, input logic [35:0] d);
        @(negedge clk);
        wr_req = 1'b1; wr_addr = a; wr_data = d;
        #1;
        chk("wr_ack", {63'd0, wr_ack}, 64'd1);
        @(negedge clk);
        wr_req = 1'b0;
        $display("write addr=%0h data=%0h", a, d);
    endtask

    task automatic do_read(input logic [18:0] a, input logic [35:0] exp);
        int lat;
        @(negedge clk);
        rd_req = 1'b1; rd_addr = a;
        #1;
        chk("rd_ack", {63'd0, rd_ack}, 64'd1);
        @(negedge clk);
        rd_req = 1'b0;
        lat = 1;
        while (rd_valid !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("rd_latency", 64'(lat), 64'd4);
        chk("rd_data", {28'd0, rd_data}, {28'd0, exp});
        $display("read addr=%0h data=%0h latency=%0d", a, rd_data, lat);
    endtask

    typedef struct {
        logic rd_req;
        logic wr_req;
        logic exp_rd_ack;
        logic exp_wr_ack;
    } vec_t;

    vec_t vecs [15];

    initial begin
        int n;

        // arbitration table: idle, read only, write only, then 12 cycles of
        // contention with STARVE_LIMIT=4 -> R,R,R,R,W,R,R,R,R,W,R,R
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 12; i++) begin
            if (i == 4 || i == 9) vecs[3+i] = '{1'b1, 1'b1, 1'b0, 1'b1};
            else                  vecs[3+i] = '{1'b1, 1'b1, 1'b1, 1'b0};
        end

        // ---- reset with random inputs ----
        reset = 1'b1;
        rd_req = 0; rd_addr = '0; wr_req = 0; wr_addr = '0; wr_data = '0; clear_start = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            rd_req      = 1'($urandom_range(0, 1));
            wr_req      = 1'($urandom_range(0, 1));
            clear_start = 1'($urandom_range(0, 1));
            rd_addr     = 19'($urandom);
            wr_addr     = 19'($urandom);
            wr_data     = {4'($urandom), 32'($urandom)};
            #1;
            chk("rst_rd_ack",   {63'd0, rd_ack},     64'd0);
            chk("rst_wr_ack",   {63'd0, wr_ack},     64'd0);
            chk("rst_rd_valid", {63'd0, rd_valid},   64'd0);
            chk("rst_rd_data",  {28'd0, rd_data},    64'd0);
            chk("rst_busy",     {63'd0, clear_busy}, 64'd0);
            chk("rst_cen",      {63'd0, zbt_cen},    64'd0);
            chk("rst_we",       {63'd0, zbt_we},     64'd0);
            chk("rst_addr",     {45'd0, zbt_addr},   64'd0);
            chk("rst_wdata",    {28'd0, zbt_write_data}, 64'd0);
        end
        @(negedge clk);
        reset = 1'b0; rd_req = 0; wr_req = 0; clear_start = 0;
        #1;
        chk("cen_after_reset", {63'd0, zbt_cen}, 64'd1);

        // ---- write then read in consecutive cycles ----
        @(negedge clk);
        wr_req = 1'b1; wr_addr = 19'd5; wr_data = 36'hABCDE1234;
        #1;
        chk("wa_wr_ack", {62'd0, rd_ack, wr_ack}, 64'd1);
        @(negedge clk);
        wr_req = 1'b0; rd_req = 1'b1; rd_addr = 19'd5;
        #1;
        chk("raw_rd_ack", {62'd0, rd_ack, wr_ack}, 64'd2);
        chk("wa_issue", {8'd0, zbt_we, zbt_addr, zbt_write_data}, {8'd0, 1'b1, 19'd5, 36'hABCDE1234});
        $display("write addr=5 data=abcde1234");
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            rd_req = 1'b0;
            if (k == 1) chk("ra_issue", {44'd0, zbt_we, zbt_addr}, {44'd0, 1'b0, 19'd5});
            if (k < 4) chk("raw_early_valid", {63'd0, rd_valid}, 64'd0);
        end
        chk("raw_valid", {63'd0, rd_valid}, 64'd1);
        chk("raw_data", {28'd0, rd_data}, {28'd0, 36'hABCDE1234});
        $display("read addr=5 data=%0h", rd_data);
        @(negedge clk);
        chk("raw_valid_pulse", {63'd0, rd_valid}, 64'd0);

        // ---- arbitration table ----
        foreach (vecs[i]) begin
            @(negedge clk);
            rd_req = vecs[i].rd_req; rd_addr = 19'd100;
            wr_req = vecs[i].wr_req; wr_addr = 19'd101; wr_data = 36'(i);
            #1;
            chk($sformatf("arb_vec%0d", i), {62'd0, rd_ack, wr_ack},
                {62'd0, vecs[i].exp_rd_ack, vecs[i].exp_wr_ack});
            $display("vec %0d rd_req=%b wr_req=%b -> rd_ack=%b wr_ack=%b",
                     i, rd_req, wr_req, rd_ack, wr_ack);
        end
        @(negedge clk);
        rd_req = 0; wr_req = 0;
        repeat (6) @(negedge clk);

        // ---- idle cycles: untagged reads only ----
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("idle_we",    {63'd0, zbt_we},   64'd0);
            chk("idle_valid", {63'd0, rd_valid}, 64'd0);
            chk("idle_cen",   {63'd0, zbt_cen},  64'd1);
        end

        // ---- fill with a read held pending ----
        @(negedge clk);
        rd_req = 1'b1; rd_addr = 19'd3; clear_start = 1'b1;
        #1;
        chk("clear_wins", {62'd0, rd_ack, wr_ack}, 64'd0);
        @(negedge clk);
        clear_start = 1'b0;
        n = 0;
        while (clear_busy === 1'b1 && n < 20) begin
            chk("fill_no_ack", {62'd0, rd_ack, wr_ack}, 64'd0);
            if (n >= 1) chk("fill_issue", {44'd0, zbt_we, zbt_addr}, {44'd0, 1'b1, 19'(n - 1)});
            n++;
            clear_start = (n == 3);   // a pulse mid-fill must not restart it
            @(negedge clk);
        end
        clear_start = 1'b0;
        chk("fill_len", 64'(n), 64'd8);
        chk("fill_last_addr", {44'd0, zbt_we, zbt_addr}, {44'd0, 1'b1, 19'd7});
        chk("first_ack_after_fill", {62'd0, rd_ack, wr_ack}, 64'd2);
        $display("fill done after %0d busy cycles", n);
        @(negedge clk);
        rd_req = 1'b0;
        repeat (6) @(negedge clk);
        for (int a = 0; a < 8; a++) do_read(19'(a), 36'h0);
        do_read(19'd8, INIT_PAT | 36'd8);

        // ---- reset during fill with a read in flight ----
        @(negedge clk);
        rd_req = 1'b1; rd_addr = 19'd2;
        #1;
        chk("mid_rd_ack", {63'd0, rd_ack}, 64'd1);
        @(negedge clk);
        rd_req = 1'b0; clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        chk("mid_busy", {63'd0, clear_busy}, 64'd1);
        reset = 1'b1;
        #1;
        chk("mid_cen_low", {63'd0, zbt_cen}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int c = 0; c < 8; c++) begin
            chk("mid_busy_cleared", {63'd0, clear_busy}, 64'd0);
            chk("mid_no_valid",     {63'd0, rd_valid},   64'd0);
            @(negedge clk);
        end
        $display("reset during fill: fill abandoned, in-flight read dropped");
        do_read(19'd9, INIT_PAT | 36'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
